// File: rtl/tour_cmd_seq.sv
// Replays a solved knight's tour as Y/X move-command pairs, otherwise forwards UART commands.
// Optional macro TOUR_ABORT_EN: a UART command with opcode 4'hF aborts a tour in progress.
module tour_cmd_seq #(
    parameter int unsigned MAX_MOVES = 24,
    parameter int unsigned IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [IDX_W-1:0] tour_len,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             busy
);

    localparam logic [7:0] HDG_N     = 8'h00;
    localparam logic [7:0] HDG_W     = 8'h3F;
    localparam logic [7:0] HDG_S     = 8'h7F;
    localparam logic [7:0] HDG_E     = 8'hBF;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_MOVES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        V_ISSUE = 3'd1,
        V_WAIT  = 3'd2,
        H_ISSUE = 3'd3,
        H_WAIT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             busy_q, busy_d;

    logic [2:0]       sel;
    logic [7:0]       y_hdg, x_hdg;
    logic [3:0]       y_sq, x_sq;
    logic [IDX_W-1:0] len_clamped;
    logic [15:0]      y_cmd, x_cmd;
    logic             abort_c;

    // Lowest set bit wins; an all-zero move falls back to bit 0.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) sel = 3'(i);
        end
    end

    always_comb begin
        y_hdg = HDG_N;
        y_sq  = 4'd2;
        x_hdg = HDG_E;
        x_sq  = 4'd1;
        case (sel)
            3'd0: begin y_hdg = HDG_N; y_sq = 4'd2; x_hdg = HDG_E; x_sq = 4'd1; end
            3'd1: begin y_hdg = HDG_N; y_sq = 4'd2; x_hdg = HDG_W; x_sq = 4'd1; end
            3'd2: begin y_hdg = HDG_N; y_sq = 4'd1; x_hdg = HDG_W; x_sq = 4'd2; end
            3'd3: begin y_hdg = HDG_S; y_sq = 4'd1; x_hdg = HDG_W; x_sq = 4'd2; end
            3'd4: begin y_hdg = HDG_S; y_sq = 4'd2; x_hdg = HDG_W; x_sq = 4'd1; end
            3'd5: begin y_hdg = HDG_S; y_sq = 4'd2; x_hdg = HDG_E; x_sq = 4'd1; end
            3'd6: begin y_hdg = HDG_S; y_sq = 4'd1; x_hdg = HDG_E; x_sq = 4'd2; end
            default: begin y_hdg = HDG_N; y_sq = 4'd1; x_hdg = HDG_E; x_sq = 4'd2; end
        endcase
    end

    assign y_cmd       = {4'h2, y_hdg, y_sq};
    assign x_cmd       = {4'h3, x_hdg, x_sq};
    assign len_clamped = (tour_len > MAX_IDX) ? MAX_IDX : tour_len;

`ifdef TOUR_ABORT_EN
    assign abort_c = (state_q != IDLE) && cmd_rdy_UART && (cmd_UART[15:12] == 4'hF);
`else
    assign abort_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
            last_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    // Next state plus the combinational command/response mux.
    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        last_d    = last_q;
        cmd       = 16'h0000;
        cmd_rdy   = 1'b0;
        resp      = RESP_BUSY;
        case (state_q)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
                if (start_tour && (tour_len != '0)) begin
                    last_d    = len_clamped - IDX_W'(1);
                    mv_indx_d = '0;
                    state_d   = V_ISSUE;
                end
            end
            V_ISSUE: begin
                cmd     = y_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = V_WAIT;
            end
            V_WAIT: begin
                cmd = y_cmd;
                if (send_resp) state_d = H_ISSUE;
            end
            H_ISSUE: begin
                cmd     = x_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = H_WAIT;
            end
            H_WAIT: begin
                cmd = x_cmd;
                if (mv_indx_q == last_q) resp = RESP_DONE;
                if (send_resp) begin
                    if (mv_indx_q == last_q) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                        state_d   = V_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_c) begin
            state_d   = IDLE;
            mv_indx_d = '0;
            cmd_rdy   = 1'b0;
            resp      = RESP_DONE;
        end
        busy_d = (state_d != IDLE);
    end

    assign mv_indx = mv_indx_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: stimulus pushes expected tour commands, a monitor pops them.
module tb_tour_cmd_seq;

    localparam int unsigned IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_tour;
    logic [IDX_W-1:0] tour_len;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [7:0]       resp;
    logic             busy;

    logic [7:0]  mem [0:31];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          peak  = 0;
    bit          prev_pres = 1'b0;

    tour_cmd_seq #(.MAX_MOVES(24), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_tour   (start_tour),
        .tour_len     (tour_len),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    assign move = mem[mv_indx];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Each new tour command presentation pops one expected value.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && cmd_rdy && !prev_pres) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_cmd: got %0h, expected none", cmd);
                end else begin
                    chk("tour_cmd", 32'(cmd), 32'(exp_q.pop_front()));
                    chk("issue_resp", 32'(resp), 32'h5A);
                end
            end
            if (busy && (int'(mv_indx) > peak)) peak = int'(mv_indx);
        end
        prev_pres = busy && cmd_rdy;
    end

    task automatic start(input logic [IDX_W-1:0] len);
        tour_len   = len;
        start_tour = 1'b1;
        @(posedge clk);
        #1 start_tour = 1'b0;
        @(negedge clk);
        if (len != '0) begin
            chk("start_lat", 32'(cmd_rdy), 32'h1);
            chk("start_idx", 32'(mv_indx), 32'h0);
        end
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (cmd_rdy !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30) begin
            n_vec++;
            n_err++;
            $display("FAIL rdy_timeout: got cmd_rdy=%0b, expected 1", cmd_rdy);
        end
    endtask

    task automatic take_cmd();
        wait_rdy();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        chk("clr_drop", 32'(cmd_rdy), 32'h0);
        chk("busy_hold", 32'(busy), 32'h1);
    endtask

    task automatic give_resp(input bit fin);
        chk("wait_resp", 32'(resp), fin ? 32'hA5 : 32'h5A);
        send_resp = 1'b1;
        @(posedge clk);
        #1 send_resp = 1'b0;
        @(negedge clk);
        if (fin) begin
            chk("end_busy", 32'(busy), 32'h0);
        end else begin
            chk("resp_to_rdy", 32'(cmd_rdy), 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h01;
        rst = 1'b1; start_tour = 1'b0; tour_len = '0;
        cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;

        // Reset / IDLE pass-through
        #3;
        chk("rst_cmd", 32'(cmd), 32'h2003);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h1);
        chk("rst_resp", 32'(resp), 32'hA5);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_idx", 32'(mv_indx), 32'h0);
        #19 rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd", 32'(cmd), 32'h2003);
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
        chk("idle_rdy_off", 32'(cmd_rdy), 32'h0);

        // Two-move tour with busy-time inputs in V_WAIT of move 0
        mem[0] = 8'h01; mem[1] = 8'h08;
        exp_q.push_back(16'h2002); exp_q.push_back(16'h3BF1);
        exp_q.push_back(16'h27F1); exp_q.push_back(16'h33F2);
        start(5'd2);
        take_cmd();
        cmd_UART = 16'h2001; cmd_rdy_UART = 1'b1; tour_len = 5'd5; start_tour = 1'b1;
        #1 chk("uart_blocked", 32'(cmd_rdy), 32'h0);
        @(posedge clk);
        #1 start_tour = 1'b0; cmd_rdy_UART = 1'b0;
        @(negedge clk);
        chk("start_ignored_idx", 32'(mv_indx), 32'h0);
        chk("start_ignored_rdy", 32'(cmd_rdy), 32'h0);
        give_resp(1'b0); take_cmd(); give_resp(1'b0);
        chk("move1_idx", 32'(mv_indx), 32'h1);
        take_cmd(); give_resp(1'b0); take_cmd(); give_resp(1'b1);
        chk("q_two_move", 32'(exp_q.size()), 32'h0);

        // tour_len 0 is ignored
        start(5'd0);
        chk("len0_busy", 32'(busy), 32'h0);
        chk("len0_rdy", 32'(cmd_rdy), 32'h0);
        repeat (2) @(negedge clk);
        chk("len0_stay", 32'(busy), 32'h0);

        // tour_len 31 clamps to 24 moves
        for (int i = 0; i < 32; i++) mem[i] = 8'h01;
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(16'h2002); exp_q.push_back(16'h3BF1);
        end
        start(5'd31);
        for (int i = 0; i < 24; i++) begin
            take_cmd(); give_resp(1'b0); take_cmd(); give_resp(i == 23);
        end
        chk("peak_idx", 32'(peak), 32'd23);
        repeat (3) @(negedge clk);
        chk("no_extra_rdy", 32'(cmd_rdy), 32'h0);
        chk("no_extra_busy", 32'(busy), 32'h0);
        chk("q_clamp", 32'(exp_q.size()), 32'h0);

        // Non-one-hot 8'h30 -> S2W1
        mem[0] = 8'h30;
        exp_q.push_back(16'h27F2); exp_q.push_back(16'h33F1);
        start(5'd1);
        take_cmd(); give_resp(1'b0); take_cmd(); give_resp(1'b1);

        // 8'h00 -> N2E1, with clr and send_resp together in V_ISSUE
        mem[0] = 8'h00;
        exp_q.push_back(16'h2002); exp_q.push_back(16'h3BF1);
        start(5'd1);
        wait_rdy();
        clr_cmd_rdy = 1'b1; send_resp = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        @(negedge clk);
        chk("both_drop", 32'(cmd_rdy), 32'h0);
        repeat (3) @(negedge clk);
        chk("send_not_kept", 32'(cmd_rdy), 32'h0);
        give_resp(1'b0); take_cmd(); give_resp(1'b1);
        chk("q_nonhot", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset mid-tour
        mem[0] = 8'h01; mem[1] = 8'h01; mem[2] = 8'h01;
        exp_q.push_back(16'h2002); exp_q.push_back(16'h3BF1); exp_q.push_back(16'h2002);
        start(5'd3);
        take_cmd(); give_resp(1'b0); take_cmd(); give_resp(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_idx", 32'(mv_indx), 32'h0);
        chk("arst_resp", 32'(resp), 32'hA5);
        chk("arst_rdy", 32'(cmd_rdy), 32'h0);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("arst_hold", 32'(busy), 32'h0);
        chk("q_arst", 32'(exp_q.size()), 32'h0);

        // Opcode-F UART command in V_WAIT of move 3
        for (int i = 0; i < 5; i++) mem[i] = 8'h01;
`ifdef TOUR_ABORT_EN
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'h2002); exp_q.push_back(16'h3BF1);
        end
        exp_q.push_back(16'h2002);
`else
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'h2002); exp_q.push_back(16'h3BF1);
        end
`endif
        start(5'd5);
        for (int i = 0; i < 3; i++) begin
            take_cmd(); give_resp(1'b0); take_cmd(); give_resp(1'b0);
        end
        take_cmd();
        chk("v_wait3_idx", 32'(mv_indx), 32'h3);
        cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
`ifdef TOUR_ABORT_EN
        #1;
        chk("abort_rdy", 32'(cmd_rdy), 32'h0);
        chk("abort_resp", 32'(resp), 32'hA5);
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_idx", 32'(mv_indx), 32'h0);
        chk("abort_idle_resp", 32'(resp), 32'hA5);
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
`else
        #1;
        chk("f_ignored_rdy", 32'(cmd_rdy), 32'h0);
        chk("f_ignored_resp", 32'(resp), 32'h5A);
        @(posedge clk);
        #1;
        chk("f_ignored_busy", 32'(busy), 32'h1);
        chk("f_ignored_idx", 32'(mv_indx), 32'h3);
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
        give_resp(1'b0); take_cmd(); give_resp(1'b0);
        take_cmd(); give_resp(1'b0); take_cmd(); give_resp(1'b1);
`endif
        chk("q_final", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
